reg_scan_reader: RTL and testbench

- Sequential reader that walks the register bank's debug read port and emits every register's contents as a valid/ready word stream.
- Drives the bank's result-register select and samples its combinational result data.
- Sits between the register bank and the top-level debug/display logic, which currently sees only one register at a time.
- Used for post-run register dumps and bench self-checks.

---
 rtl/reg_scan_reader_if.sv | 30 +++
 rtl/reg_scan_reader.sv | 121 ++++++++++++
 tb/tb_reg_scan_reader.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/reg_scan_reader_if.sv
// reg_scan_reader_if: bank read port plus outgoing valid/ready word stream.
// master drives reg_sel and the stream; slave is the bank/consumer side.
interface reg_scan_reader_if #(
    parameter int DATA_W = 32
);
    logic [3:0]        reg_sel;
    logic [DATA_W-1:0] reg_data_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        out_idx;

    modport master (
        output reg_sel,
        output out_valid,
        output out_data,
        output out_idx,
        input  reg_data_in,
        input  out_ready
    );

    modport slave (
        input  reg_sel,
        input  out_valid,
        input  out_data,
        input  out_idx,
        output reg_data_in,
        output out_ready
    );
endinterface

// File: rtl/reg_scan_reader.sv
// reg_scan_reader: walks the bank read port and streams each register as a word.
// Macro REG_SCAN_CHKSUM_EN adds an XOR checksum over the accepted words.
module reg_scan_reader #(
    parameter int NUM_REGS  = 16,
    parameter int FIRST_REG = 0,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    reg_scan_reader_if.master bus,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] chksum
);
    typedef enum logic [1:0] {IDLE, SEL, PRESENT, DONE} state_t;

    localparam logic [3:0] FIRST = 4'(FIRST_REG);
    localparam logic [3:0] LAST  = 4'(FIRST_REG + NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [3:0]        sel_q, sel_d;
    logic [3:0]        idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              hs;

    assign hs = (state_q == PRESENT) & bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d   = FIRST;
                    state_d = SEL;
                end
            end
            SEL: begin
                // bank read is combinational, so capture in the select cycle
                data_d  = bus.reg_data_in;
                idx_d   = sel_q;
                valid_d = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (hs) begin
                    valid_d = 1'b0;
                    if (idx_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        sel_d   = sel_q + 4'd1;
                        state_d = SEL;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                sel_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            valid_d = 1'b0;
            sel_d   = '0;
            done_d  = 1'b0;
        end
    end

`ifdef REG_SCAN_CHKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (state_q == IDLE && start) begin
            sum_q <= '0;
        end else if (hs && !abort) begin
            sum_q <= sum_q ^ data_q;
        end
    end

    assign chksum = sum_q;
`else
    assign chksum = '0;
`endif

    assign bus.reg_sel   = sel_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_idx   = idx_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
endmodule

// File: tb/tb_reg_scan_reader.sv
// tb_reg_scan_reader: directed scans over a modelled register bank.
// Covers timing, backpressure, ignored start, abort, async reset, checksum.
module tb_reg_scan_reader;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] chksum;
    logic [31:0] bank [16];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

`ifdef REG_SCAN_CHKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    localparam logic [31:0] SUM_A = CK ? 32'hCFBCAFFE : 32'h0;
    localparam logic [31:0] SUM_B = CK ? 32'hFFFFFFFF : 32'h0;

    reg_scan_reader_if #(.DATA_W(32)) bus ();

    assign bus.reg_data_in = bank[bus.reg_sel];

    reg_scan_reader #(
        .NUM_REGS  (16),
        .FIRST_REG (0),
        .DATA_W    (32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .abort  (abort),
        .bus    (bus.master),
        .busy   (busy),
        .done   (done),
        .chksum (chksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({pfx, "_data"}, bus.out_data, 32'd0);
        chk({pfx, "_idx"}, 32'(bus.out_idx), 32'd0);
        chk({pfx, "_sel"}, 32'(bus.reg_sel), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_done"}, 32'(done), 32'd0);
        chk({pfx, "_sum"}, chksum, 32'd0);
    endtask

    // start is driven just after edge n and sampled at edge n+1
    task automatic scan(input int stall_k, input int retrig_k,
                        input int abort_k, input int rst_k,
                        input bit with_abort, input logic [31:0] exp_sum);
        int n, k, stall, firstv, ndone, donec, extra;
        bit pulsed, fin;
        k = 0; stall = 0; firstv = -1; ndone = 0; donec = 0;
        pulsed = 1'b0; fin = 1'b0;
        extra = (stall_k >= 0) ? 5 : 0;
        bus.out_ready = 1'b1;
        start = 1'b1;
        abort = with_abort;
        n = cyc;
        @(negedge clk);
        for (int t = 0; t < 100 && !fin; t++) begin
            start = 1'b0;
            abort = 1'b0;
            if (done) begin
                ndone++;
                donec = cyc;
                chk("done_edge", cyc, n + 34 + extra);
            end
            if (ndone > 0 && cyc >= donec + 3) fin = 1'b1;
            if (!fin && bus.out_valid) begin
                if (firstv < 0) begin
                    firstv = cyc;
                    chk("first_valid", cyc, n + 2);
                end
                chk("idx", 32'(bus.out_idx), k);
                chk("data", bus.out_data, bank[k]);
                chk("busy", 32'(busy), 32'd1);
                if (k == rst_k) begin
                    reset = 1'b1;
                    #1;
                    chk_zero("rst");
                    @(negedge clk);
                    reset = 1'b0;
                    fin = 1'b1;
                end else if (k == abort_k) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    chk("abort_valid", 32'(bus.out_valid), 32'd0);
                    chk("abort_sel", 32'(bus.reg_sel), 32'd0);
                    chk("abort_busy", 32'(busy), 32'd0);
                    for (int j = 0; j < 4; j++) begin
                        chk("abort_done", 32'(done), 32'd0);
                        @(negedge clk);
                    end
                    chk("abort_sum", chksum, exp_sum);
                    fin = 1'b1;
                end else begin
                    bus.out_ready = !(k == stall_k && stall < 5);
                    if (!bus.out_ready) stall++;
                    if (k == retrig_k && !pulsed) begin
                        start = 1'b1;
                        pulsed = 1'b1;
                    end
                    if (bus.out_ready) begin
                        chk("hs_edge", cyc + 1,
                            n + 3 + 2 * k + ((stall_k >= 0 && k >= stall_k) ? 5 : 0));
                        k++;
                    end
                end
            end
            if (!fin) @(negedge clk);
        end
        if (abort_k < 0 && rst_k < 0) begin
            chk("words", k, 16);
            chk("done_count", ndone, 1);
            chk("chksum", chksum, exp_sum);
            chk("idle_busy", 32'(busy), 32'd0);
        end
        bus.out_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) bank[i] = 32'h0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_zero("idle");
        chk("idle_sum", chksum, 32'd0);

        bank[1] = 32'h11111111;
        bank[5] = 32'hDEADBEEF;
        scan(-1, -1, -1, -1, 1'b0, SUM_A);
        scan(5, -1, -1, -1, 1'b0, SUM_A);
        scan(-1, 3, -1, -1, 1'b0, SUM_A);
        scan(-1, -1, 7, -1, 1'b0, SUM_A);
        scan(-1, -1, -1, -1, 1'b1, SUM_A);
        scan(-1, -1, -1, 9, 1'b0, SUM_A);
        @(negedge clk);

        bank[1] = 32'h0;
        bank[5] = 32'h0;
        bank[2] = 32'hF0F0F0F0;
        bank[3] = 32'h0F0F0F0F;
        scan(-1, -1, -1, -1, 1'b0, SUM_B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
